// File: rtl/io_responder_pkg.sv
// io_responder_pkg: register map, CTRL bit positions and the ID constant
// shared by the io_responder RTL.
//
// Contents:
//   reg_off_e      register offsets inside the 8-byte window
//   CTRL_*         bit positions inside the CTRL register
//   STATUS_EXPIRED bit position of the expiry flag in STATUS
//   ID_VALUE       constant returned by the ID register
//   ctrl_t         packed view of the implemented CTRL bits
//   ctrl_to_byte   CTRL as seen on the bus (unused bits read 0)
package io_responder_pkg;

  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_STATUS    = 3'd1,
    REG_RELOAD_LO = 3'd2,
    REG_RELOAD_HI = 3'd3,
    REG_COUNT_LO  = 3'd4,
    REG_COUNT_HI  = 3'd5,
    REG_HEX       = 3'd6,
    REG_ID        = 3'd7
  } reg_off_e;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_AUTO      = 2;
  localparam int STATUS_EXPIRED = 0;

  localparam logic [7:0] ID_VALUE = 8'h65;

  // Field order matches the CTRL bit positions above.
  typedef struct packed {
    logic auto_reload;
    logic irq_en;
    logic en;
  } ctrl_t;

  function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
    return {5'b0, c};
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// io_responder_if: CPU bus between a bus master and the io_responder.
//
// Signals:
//   address     CPU bus address
//   data_write  CPU write data
//   read_write  1 = write, 0 = read
//   data_read   registered read data (one cycle after address)
//   sel         registered window hit for the previous-cycle address
//
// Modports: master (CPU side), slave (peripheral side).
interface io_responder_if;
  logic [15:0] address;
  logic [7:0]  data_write;
  logic        read_write;
  logic [7:0]  data_read;
  logic        sel;

  modport master (
    output address, data_write, read_write,
    input  data_read, sel
  );

  modport slave (
    input  address, data_write, read_write,
    output data_read, sel
  );
endinterface

// File: rtl/io_responder_tick.sv
// tick_gen: prescaler producing a one-cycle tick every PRESCALE enabled
// clock cycles.
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-low reset
//   clear   restart the prescale period
//   enable  count while high; counter held at 0 while low
//   tick    high for the last cycle of each period (combinational
//           from the counter register)
module tick_gen #(
  parameter int PRESCALE = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // A 1-bit counter keeps PRESCALE = 1 legal; it simply stays at 0.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // NOTE: sequential state is written only with <= so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || !enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_responder.sv
// io_responder: 8-byte memory-mapped peripheral with a 16-bit down-counting
// timer, expiry flag/interrupt, a HEX display register and an ID register.
//
// Parameters:
//   BASE_ADDR  8-byte-aligned base of the register window (default 16'hD000)
//   PRESCALE   clk cycles per timer tick, >= 1 (default 2500)
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   bus        io_responder_if.slave: address, data_write, read_write in;
//              data_read, sel out (both registered)
//   hex_value  HEX register contents
//   irq        level interrupt, STATUS[0] & CTRL.IRQ_EN
//
// Configuration macro: IO_RESPONDER_IRQ_EN. When undefined, irq is tied 0
// and CTRL[1] reads 0 and ignores writes.
module io_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter int          PRESCALE  = 2500
) (
  input  logic          clk,
  input  logic          rst,
  io_responder_if.slave bus,
  output logic [7:0]    hex_value,
  output logic          irq
);
  import io_responder_pkg::*;

  logic        hit, wr_hit, rd_hit;
  reg_off_e    offset;
  ctrl_t       ctrl;
  logic        status;
  logic [15:0] reload, count, count_next;
  logic [7:0]  shadow, hex_q, rd_mux;
  logic        tick, en_next, expire, en_rise, status_clr, irq_en_wr;

  assign hit    = (bus.address[15:3] == BASE_ADDR[15:3]);
  assign offset = reg_off_e'(bus.address[2:0]);
  assign wr_hit = hit &  bus.read_write;
  assign rd_hit = hit & ~bus.read_write;

  // Only a 0->1 transition of EN loads COUNT; rewriting EN=1 while running
  // leaves the count alone.
  assign en_rise    = wr_hit && (offset == REG_CTRL) && !ctrl.en
                      && bus.data_write[CTRL_EN];
  assign status_clr = wr_hit && (offset == REG_STATUS)
                      && bus.data_write[STATUS_EXPIRED];

`ifdef IO_RESPONDER_IRQ_EN
  assign irq_en_wr = bus.data_write[CTRL_IRQ_EN];
  assign irq       = status & ctrl.irq_en;
`else
  assign irq_en_wr = 1'b0;
  assign irq       = 1'b0;
`endif

  assign hex_value = hex_q;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (en_rise),
    .enable (ctrl.en),
    .tick   (tick)
  );

  // Timer next state. COUNT == 0 on a tick also expires, so a reload value
  // of 0 fires on the first tick instead of wrapping.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    count_next = count;
    en_next    = ctrl.en;
    expire     = 1'b0;
    if (tick) begin
      if (count <= 16'd1) begin
        expire = 1'b1;
        if (ctrl.auto_reload) begin
          count_next = reload;
        end else begin
          count_next = '0;
          en_next    = 1'b0;
        end
      end else begin
        count_next = count - 16'd1;
      end
    end
  end

  // Read mux sees pre-edge register values; COUNT_HI returns the shadow
  // captured by the last COUNT_LO read so a 16-bit read is coherent.
  always_comb begin
    rd_mux = '0;
    case (offset)
      REG_CTRL:      rd_mux = ctrl_to_byte(ctrl);
      REG_STATUS:    rd_mux = {7'b0, status};
      REG_RELOAD_LO: rd_mux = reload[7:0];
      REG_RELOAD_HI: rd_mux = reload[15:8];
      REG_COUNT_LO:  rd_mux = count[7:0];
      REG_COUNT_HI:  rd_mux = shadow;
      REG_HEX:       rd_mux = hex_q;
      REG_ID:        rd_mux = ID_VALUE;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl          <= '0;
      status        <= 1'b0;
      reload        <= '0;
      count         <= '0;
      shadow        <= '0;
      hex_q         <= '0;
      bus.data_read <= '0;
      bus.sel       <= 1'b0;
    end else begin
      ctrl.en <= en_next;
      count   <= count_next;
      // A simultaneous expiry wins over a software clear.
      status  <= (status & ~status_clr) | expire;

      // Bus writes are applied after the timer update so a CTRL write
      // overrides the timer's own EN clear in the same cycle.
      if (wr_hit) begin
        case (offset)
          REG_CTRL: begin
            ctrl.en          <= bus.data_write[CTRL_EN];
            ctrl.irq_en      <= irq_en_wr;
            ctrl.auto_reload <= bus.data_write[CTRL_AUTO];
            if (en_rise) count <= reload;
          end
          REG_RELOAD_LO: reload[7:0]  <= bus.data_write;
          REG_RELOAD_HI: reload[15:8] <= bus.data_write;
          REG_HEX:       hex_q        <= bus.data_write;
          default: ;
        endcase
      end

      if (rd_hit && (offset == REG_COUNT_LO)) shadow <= count[15:8];

      bus.data_read <= rd_hit ? rd_mux : 8'h00;
      bus.sel       <= hit;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: self-checking bench for io_responder. Two instances
// share one bus stimulus: dut_a with PRESCALE=4 and dut_b with PRESCALE=1.
// Directed table vectors and hand-written sequences use constant
// expectations; a randomized phase compares both instances against a
// behavioural model evaluated once per clock.
module tb_io_responder;

  localparam logic [15:0] BASE = 16'hD000;
`ifdef IO_RESPONDER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        rw = 1'b0;
  logic [7:0]  hex_a, hex_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  io_responder_if bus_a ();
  io_responder_if bus_b ();

  assign bus_a.address    = addr;
  assign bus_a.data_write = wdata;
  assign bus_a.read_write = rw;
  assign bus_b.address    = addr;
  assign bus_b.data_write = wdata;
  assign bus_b.read_write = rw;

  io_responder #(.BASE_ADDR(BASE), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .hex_value(hex_a), .irq(irq_a));

  io_responder #(.BASE_ADDR(BASE), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .hex_value(hex_b), .irq(irq_b));

  // ---------------- reference model ----------------
  typedef struct packed {
    bit en; bit irq_en; bit auto_r; bit status; bit exp_sel;
    int reload; int count; int shadow; int hex; int phase; int exp_dr;
  } model_t;

  model_t mdl [2];
  int     presc [2];

  function automatic model_t model_next(input model_t s, input int p,
                                        input logic [15:0] a,
                                        input logic [7:0] d, input bit w);
    model_t n;
    bit     hit, tick, expired;
    int     off;
    n       = s;
    hit     = (a[15:3] == BASE[15:3]);
    off     = int'(a[2:0]);
    tick    = s.en && ((s.phase + 1) % p == 0);
    expired = tick && (s.count <= 1);
    n.exp_sel = hit;
    n.exp_dr  = 0;
    if (hit && !w) begin
      case (off)
        0: n.exp_dr = 4 * int'(s.auto_r) + 2 * int'(s.irq_en) + int'(s.en);
        1: n.exp_dr = int'(s.status);
        2: n.exp_dr = s.reload % 256;
        3: n.exp_dr = s.reload / 256;
        4: begin n.exp_dr = s.count % 256; n.shadow = s.count / 256; end
        5: n.exp_dr = s.shadow;
        6: n.exp_dr = s.hex;
        default: n.exp_dr = 'h65;
      endcase
    end
    n.phase = s.en ? (s.phase + 1) % p : 0;
    if (tick) begin
      if (expired) begin
        n.status = 1'b1;
        if (s.auto_r) n.count = s.reload;
        else begin n.count = 0; n.en = 1'b0; end
      end else begin
        n.count = s.count - 1;
      end
    end
    if (hit && w) begin
      case (off)
        0: begin
          if (!s.en && d[0]) n.count = s.reload;
          n.en     = d[0];
          n.irq_en = d[1] && HAS_IRQ;
          n.auto_r = d[2];
        end
        1: if (d[0] && !expired) n.status = 1'b0;
        2: n.reload = (s.reload / 256) * 256 + int'(d);
        3: n.reload = int'(d) * 256 + s.reload % 256;
        6: n.hex = int'(d);
        default: ;
      endcase
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic check_model(input int k, input string tag);
    int dr, sl, hx, iq;
    if (k == 0) begin
      dr = bus_a.data_read; sl = bus_a.sel; hx = hex_a; iq = irq_a;
    end else begin
      dr = bus_b.data_read; sl = bus_b.sel; hx = hex_b; iq = irq_b;
    end
    check($sformatf("%s dut%0d data_read", tag, k), dr, mdl[k].exp_dr);
    check($sformatf("%s dut%0d sel", tag, k), sl, int'(mdl[k].exp_sel));
    check($sformatf("%s dut%0d hex_value", tag, k), hx, mdl[k].hex);
    check($sformatf("%s dut%0d irq", tag, k), iq,
          int'(mdl[k].status && mdl[k].irq_en));
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic step(input logic [15:0] a, input logic [7:0] d, input bit w);
    addr = a; wdata = d; rw = w;
    for (int k = 0; k < 2; k++) mdl[k] = model_next(mdl[k], presc[k], a, d, w);
    @(negedge clk);
  endtask

  task automatic rd_reg(input int off);
    step(BASE + 16'(off), 8'h00, 1'b0);
  endtask

  task automatic wr_reg(input int off, input logic [7:0] d);
    step(BASE + 16'(off), d, 1'b1);
  endtask

  task automatic idle();
    step(16'h0000, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    addr = '0; wdata = '0; rw = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) mdl[k] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic [15:0] a; logic [7:0] d; logic w;
    logic chk_dr; logic [7:0] dr; logic sel; logic [7:0] hex;
  } vec_t;

  vec_t vecs [14];

  logic [15:0] ra;
  logic [7:0]  rdat;
  bit          rwr;

  initial begin
    presc[0] = 4;
    presc[1] = 1;
    for (int k = 0; k < 2; k++) mdl[k] = '0;

    vecs[0]  = '{16'hD007, 8'h00, 1'b0, 1'b1, 8'h65, 1'b1, 8'h00};
    vecs[1]  = '{16'hD008, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{16'hCFFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{16'hD006, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[4]  = '{16'hD006, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5};
    vecs[5]  = '{16'hD002, 8'h34, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[6]  = '{16'hD002, 8'h00, 1'b0, 1'b1, 8'h34, 1'b1, 8'hA5};
    vecs[7]  = '{16'hD003, 8'h12, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[8]  = '{16'hD003, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1, 8'hA5};
    vecs[9]  = '{16'hD004, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5};
    vecs[10] = '{16'hD000, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[11] = '{16'hD000, 8'h00, 1'b0, 1'b1, HAS_IRQ ? 8'h07 : 8'h05, 1'b1, 8'hA5};
    vecs[12] = '{16'hD000, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[13] = '{16'hD000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5};

    // Reset state, checked asynchronously before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("reset data_read", bus_a.data_read, 0);
    check("reset sel", bus_a.sel, 0);
    check("reset hex_value", hex_a, 0);
    check("reset irq", irq_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Bus decode, register access, CTRL masking.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].a, vecs[i].d, vecs[i].w);
      if (vecs[i].chk_dr) begin
        check($sformatf("vec%0d a.data_read", i), bus_a.data_read, vecs[i].dr);
        check($sformatf("vec%0d b.data_read", i), bus_b.data_read, vecs[i].dr);
      end
      check($sformatf("vec%0d a.sel", i), bus_a.sel, vecs[i].sel);
      check($sformatf("vec%0d b.sel", i), bus_b.sel, vecs[i].sel);
      check($sformatf("vec%0d a.hex", i), hex_a, vecs[i].hex);
    end

    // One-shot expiry: PRESCALE=4, RELOAD=3 -> flag 12 clocks after enable.
    do_reset();
    wr_reg(2, 8'h03);
    wr_reg(3, 8'h00);
    wr_reg(0, 8'h03);
    repeat (11) idle();
    check("oneshot irq before expiry", irq_a, 0);
    rd_reg(1);
    check("oneshot status before expiry", bus_a.data_read, 0);
    check("oneshot irq at 12", irq_a, int'(HAS_IRQ));
    rd_reg(1);
    check("oneshot status set", bus_a.data_read, 1);
    rd_reg(0);
    check("oneshot EN cleared", bus_a.data_read, HAS_IRQ ? 2 : 0);
    wr_reg(1, 8'h01);
    check("oneshot irq after clear", irq_a, 0);
    rd_reg(1);
    check("oneshot status after clear", bus_a.data_read, 0);

    // Auto-reload: PRESCALE=1, RELOAD=2 -> expiry every 2 cycles; a clear
    // on an expiry cycle loses to the expiry.
    do_reset();
    wr_reg(2, 8'h02);
    wr_reg(0, 8'h07);
    rd_reg(1); check("auto E1 status", bus_b.data_read, 0);
    rd_reg(1); check("auto E2 status", bus_b.data_read, 0);
    rd_reg(1); check("auto E3 status", bus_b.data_read, 1);
    wr_reg(1, 8'h01);
    rd_reg(1); check("auto clear on expiry keeps flag", bus_b.data_read, 1);
    rd_reg(1); check("auto E6 status", bus_b.data_read, 1);
    wr_reg(1, 8'h01);
    rd_reg(1); check("auto clear off expiry", bus_b.data_read, 0);
    rd_reg(1); check("auto E9 status", bus_b.data_read, 1);
    check("auto irq", irq_b, int'(HAS_IRQ));

    // Coherent 16-bit COUNT read through the shadow.
    do_reset();
    wr_reg(2, 8'h00);
    wr_reg(3, 8'h01);
    wr_reg(0, 8'h01);
    rd_reg(4); check("shadow count_lo 0x0100", bus_b.data_read, 8'h00);
    rd_reg(5); check("shadow count_hi", bus_b.data_read, 8'h01);
    rd_reg(4); check("shadow count_lo 0x00FE", bus_b.data_read, 8'hFE);
    rd_reg(5); check("shadow count_hi updated", bus_b.data_read, 8'h00);
    wr_reg(0, 8'h00);

    // Reset in the middle of a running count.
    do_reset();
    wr_reg(2, 8'h05);
    wr_reg(3, 8'h00);
    wr_reg(0, 8'h03);
    wr_reg(6, 8'h5A);
    idle();
    rd_reg(7);
    check("midreset pre data_read", bus_a.data_read, 8'h65);
    #2 rst = 1'b0;
    #1;
    check("midreset data_read", bus_a.data_read, 0);
    check("midreset sel", bus_a.sel, 0);
    check("midreset hex_value", hex_a, 0);
    check("midreset irq", irq_a, 0);
    for (int k = 0; k < 2; k++) mdl[k] = '0;
    addr = '0; rw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) idle();
    rd_reg(1); check("midreset no expiry", bus_a.data_read, 0);
    rd_reg(0); check("midreset ctrl", bus_a.data_read, 0);
    check("midreset irq after release", irq_a, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ra = 16'($urandom);
      else ra = BASE + 16'($urandom_range(0, 7));
      rwr  = ($urandom_range(0, 2) == 0);
      rdat = 8'($urandom);
      if (ra == BASE + 16'd3) rdat = 8'($urandom_range(0, 1));
      if (ra == BASE + 16'd2) rdat = 8'($urandom_range(0, 12));
      step(ra, rdat, rwr);
      for (int k = 0; k < 2; k++) check_model(k, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hD000, 8-byte-aligned base of register window.
REQ-002 SHALL have parameter PRESCALE, default 2500, clk cycles per timer tick (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address  input  16  CPU bus address.
REQ-006 SHALL have port data_write  input  8  CPU write data.
REQ-007 SHALL have port read_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port data_read  output  8  registered read data.
REQ-009 SHALL have port sel  output  1  registered hit: previous-cycle address was inside window.
REQ-010 SHALL have port hex_value  output  8  HEX register contents, for seven-segment display.
REQ-011 SHALL have port irq  output  1  timer interrupt request, level, active-high.

Function
REQ-012 SHALL decode hit when address[15:3] == BASE_ADDR[15:3]; offset = address[2:0].
REQ-013 SHALL map offsets: 0 CTRL, 1 STATUS, 2 RELOAD_LO, 3 RELOAD_HI, 4 COUNT_LO, 5 COUNT_HI, 6 HEX, 7 ID (reads 8'h65).
REQ-014 SHALL treat CTRL bits: [0] EN, [1] IRQ_EN, [2] AUTO; bits [7:3] read 0, writes ignored.
REQ-015 SHALL commit writes on the same edge on which hit and read_write=1 are sampled; writes to COUNT_*, ID ignored.
REQ-016 SHALL return read data one cycle after address (registered); data_read = 0 and sel = 0 on a miss.
REQ-017 SHALL latch COUNT[15:8] into a shadow when COUNT_LO is read; a COUNT_HI read returns the shadow, not live count.
REQ-018 SHALL generate one tick every PRESCALE clk cycles while EN=1; prescaler clears while EN=0.
REQ-019 SHALL load COUNT from RELOAD on an EN 0->1 write and clear the prescaler in that cycle.
REQ-020 SHALL decrement COUNT on each tick while COUNT != 0.
REQ-021 SHALL, on a tick with COUNT == 1 or COUNT == 0 (reload 0 expires on first tick): set STATUS[0]; if AUTO=1 reload COUNT, else clear EN and hold COUNT at 0.
REQ-022 SHALL clear STATUS[0] on write of 1 to STATUS bit 0; if expiry occurs in the same cycle, STATUS[0] SHALL remain 1.
REQ-023 SHALL drive irq = STATUS[0] & IRQ_EN, combinational from registers.
REQ-024 SHALL not affect a running COUNT on RELOAD writes; new value used at next load.

Reset
REQ-025 SHALL, on rst low, immediately set CTRL, STATUS, RELOAD, COUNT, shadow, HEX, prescaler, data_read, sel to 0; irq = 0.
REQ-026 SHALL abort any in-flight count on reset; no expiry after release until re-enabled.

Configuration
REQ-027 SHALL use macro IO_RESPONDER_IRQ_EN: defined -> REQ-023 behaviour; undefined -> irq tied 0, CTRL[1] reads 0 and ignores writes.

Structure
REQ-028 SHALL place register offsets, CTRL bit indices and ID constant in shared package io_responder_pkg.
REQ-029 SHALL implement the prescaler as sub-module tick_gen (inputs clk, rst, clear, enable; output tick).

Verification
REQ-030 Reset mid-count: EN=1, COUNT=5, pull rst low -> all outputs 0 same cycle, irq 0 after release.
REQ-031 Read ID at 16'hD007 -> data_read=8'h65, sel=1 next cycle; read 16'hD008 -> data_read=0, sel=0.
REQ-032 PRESCALE=4, RELOAD=3, CTRL=8'h03 -> STATUS[0]=1, irq=1 exactly 12 clk after enabling write; EN reads 0.
REQ-033 AUTO=1, RELOAD=2, PRESCALE=1 -> STATUS set every 2 cycles; write STATUS=1 on expiry cycle -> flag stays 1.
REQ-034 COUNT=16'h0100 at COUNT_LO read, decrement to 16'h00FF before COUNT_HI read -> COUNT_HI returns 8'h01.
REQ-035 Write HEX=8'hA5 -> hex_value=8'hA5 next cycle; write CTRL=8'hFF -> CTRL reads 8'h07 (8'h05 without IO_RESPONDER_IRQ_EN).
